// File: rtl/uart_pkg.sv
// uart_pkg: shared frame constants and FSM state encoding for the UART transmit arbiter
package uart_pkg;
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 shifter with baud counter and bit index; start loads a byte, last_tick marks the final stop-bit clock
module uart_tx_serializer import uart_pkg::*; #(
  parameter int DIV = 1250
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 last_tick
);
  localparam int CW = $clog2(DIV);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);
  logic                 active;
  logic [CW-1:0]        cnt;
  logic [3:0]           b;
  logic [DATA_BITS-1:0] sh;
  logic                 tick;
  assign tick = cnt == CW'(DIV - 1);
  assign last_tick = active && tick && b == LAST_BIT;
  assign tx = !active ? STOP_BIT : b == 4'd0 ? START_BIT : b == LAST_BIT ? STOP_BIT : sh[0];
  // sh[0] always holds data bit b-1; shift only after a data bit has been on the line
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      active <= 1'b0;
      cnt <= '0;
      b <= '0;
      sh <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt <= '0;
      b <= '0;
      sh <= data;
    end else if (active) begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        b <= b + 4'd1;
        if (b != 4'd0) sh <= sh >> 1;
        if (b == LAST_BIT) active <= 1'b0;
      end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8N1 tx line among NREQ valid/ready byte sources; UART_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int NREQ = 4,
  parameter int FREQ = 12000000,
  parameter int BAUD = 9600,
  parameter int DIV  = FREQ / BAUD
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 frame_done
);
  logic [0:0]           state;
  logic [2:0]           win;
  logic                 accept;
  logic [DATA_BITS-1:0] sel_data;
`ifdef UART_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (req_valid[i]) win = 3'(i);
  end
`else
  logic [2:0] last;
  // lowest valid index overall covers the wrap; lowest valid above last overrides it
  always_comb begin
    win = last;
    for (int i = NREQ - 1; i >= 0; i--) if (req_valid[i]) win = 3'(i);
    for (int i = NREQ - 1; i >= 0; i--) if (req_valid[i] && 3'(i) > last) win = 3'(i);
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) last <= 3'(NREQ - 1);
    else if (accept) last <= win;
`endif
  assign accept = nrst && state == IDLE && |req_valid;
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && win == 3'(i);
      if (win == 3'(i)) sel_data = req_data[8*i +: 8];
    end
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state <= IDLE;
      busy <= 1'b0;
      grant_id <= '0;
    end else if (accept) begin
      state <= SEND;
      busy <= 1'b1;
      grant_id <= win;
    end else if (frame_done) begin
      state <= IDLE;
      busy <= 1'b0;
    end
  uart_tx_serializer #(.DIV(DIV)) ser (
    .clk(clk),
    .nrst(nrst),
    .start(accept),
    .data(sel_data),
    .tx(tx),
    .last_tick(frame_done)
  );
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven frame checks for the UART transmit arbiter at DIV=16, NREQ=4
module tb_uart_tx_arbiter;
`ifdef UART_ARB_FIXED_PRIO_EN
  localparam bit FX = 1'b1;
`else
  localparam bit FX = 1'b0;
`endif
  typedef struct packed {
    logic [3:0]  v;
    logic [31:0] d;
    logic [2:0]  eg;
    logic [7:0]  eb;
    bit          b2b;
    bit          drop;
    bit          scr;
    logic [3:0]  late;
  } vec_t;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx, busy, frame_done;
  logic [2:0]  grant_id;
  int          pass_cnt = 0;
  int          total = 0;
  vec_t        tbl [11];
  always #5 clk = ~clk;
  uart_tx_arbiter #(.NREQ(4), .FREQ(16), .BAUD(1)) dut (
    .clk(clk),
    .nrst(nrst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx(tx),
    .busy(busy),
    .grant_id(grant_id),
    .frame_done(frame_done)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic wait_ready(output int w);
    w = 0;
    while (!(|req_ready) && w < 400) begin
      @(negedge clk);
      #1;
      w++;
    end
  endtask
  task automatic run_frame(input vec_t r);
    int w, fd_at, fd_n;
    logic [9:0] obs;
    bit bad;
    req_valid = r.v;
    req_data = r.d;
    #1;
    wait_ready(w);
    chk("ready_wait", w >= 400, 0);
    if (w >= 400) return;
    if (r.b2b) chk("idle_gap", w, 0);
    chk("ready_onehot", req_ready, 4'b1 << r.eg);
    obs = '0;
    fd_at = -1;
    fd_n = 0;
    bad = 1'b0;
    for (int c = 1; c <= 160; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("grant_id", grant_id, r.eg);
        chk("ready_pulse", req_ready, 0);
        if (r.drop) req_valid = '0;
      end
      if (r.scr && c == 40) req_data = '1;
      if (c == 50 && r.late != 0) req_valid = r.late;
      if ((c - 1) % 16 == 8) obs[(c-1)/16] = tx;
      if (frame_done) begin
        fd_n++;
        fd_at = c;
      end
      if (!busy || req_ready != 0) bad = 1'b1;
    end
    chk("frame_bits", obs, {1'b1, r.eb, 1'b0});
    chk("done_at", fd_at, 160);
    chk("done_count", fd_n, 1);
    chk("busy_held", bad, 0);
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("tx_idle", tx, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int w;
    tbl[0]  = '{4'hF, 32'h44332211, 3'd0, 8'h11, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[1]  = '{4'hF, 32'h44332211, FX ? 3'd0 : 3'd1, FX ? 8'h11 : 8'h22, 1'b1, 1'b0, 1'b0, 4'h0};
    tbl[2]  = '{4'hF, 32'h44332211, FX ? 3'd0 : 3'd2, FX ? 8'h11 : 8'h33, 1'b1, 1'b0, 1'b0, 4'h0};
    tbl[3]  = '{4'hF, 32'h44332211, FX ? 3'd0 : 3'd3, FX ? 8'h11 : 8'h44, 1'b1, 1'b0, 1'b0, 4'h0};
    tbl[4]  = '{4'hF, 32'h44332211, 3'd0, 8'h11, 1'b1, 1'b1, 1'b0, 4'h0};
    tbl[5]  = '{4'h4, 32'h00540000, 3'd2, 8'h54, 1'b1, 1'b1, 1'b1, 4'h0};
    tbl[6]  = '{4'h8, 32'hA5003C00, 3'd3, 8'hA5, 1'b1, 1'b1, 1'b0, 4'h2};
    tbl[7]  = '{4'h2, 32'hA5003C00, 3'd1, 8'h3C, 1'b1, 1'b1, 1'b0, 4'h0};
    tbl[8]  = '{4'hA, 32'hC3005A00, FX ? 3'd1 : 3'd3, FX ? 8'h5A : 8'hC3, 1'b1, 1'b0, 1'b0, 4'h0};
    tbl[9]  = '{4'hA, 32'hC3005A00, 3'd1, 8'h5A, 1'b1, 1'b0, 1'b0, 4'h0};
    tbl[10] = '{4'hA, 32'hC3005A00, FX ? 3'd1 : 3'd3, FX ? 8'h5A : 8'hC3, 1'b1, 1'b1, 1'b0, 4'h0};
    req_valid = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ready", req_ready, 0);
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 11; i++) run_frame(tbl[i]);
    repeat (5) @(negedge clk);
    chk("grant_hold", grant_id, FX ? 3'd1 : 3'd3);
    chk("ready_none", req_ready, 0);
    req_valid = 4'h1;
    req_data = 32'h00000077;
    #1;
    wait_ready(w);
    chk("rst_seq_wait", w >= 400, 0);
    for (int c = 1; c <= 68; c++) @(negedge clk);
    chk("tx_pre_reset", tx, 0);
    nrst = 1'b0;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ready", req_ready, 0);
    chk("abort_grant", grant_id, 0);
    w = 0;
    repeat (20) begin
      @(negedge clk);
      if (frame_done || !tx) w++;
    end
    chk("abort_quiet", w, 0);
    nrst = 1'b1;
    run_frame('{4'h1, 32'h00000077, 3'd0, 8'h77, 1'b0, 1'b1, 1'b0, 4'h0});
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
